// File: rtl/data_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mux_arbiter
// Description : Round-robin N:1 payload mux with a one-entry registered output.
//               Define DATA_MUX_ARBITER_LOCK_EN to enable burst locking via req_last.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mux_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
`ifdef DATA_MUX_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_last,
`endif
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [BIT_WIDTH-1:0]         out_data,
    output logic [3:0]                   out_src,
    input  logic                         out_ready
);

    localparam int                 c_PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_INIT = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_PTR_W-1:0]   ptr_q, ptr_d;
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]           out_src_q, out_src_d;

    logic [NUM_REQ-1:0]   w_elig;
    logic [c_PTR_W-1:0]   w_grant;
    logic                 w_found;
    logic                 w_load_en;
    logic                 w_hs;

`ifdef DATA_MUX_ARBITER_LOCK_EN
    logic                 lock_q, lock_d;
    logic [c_PTR_W-1:0]   lock_idx_q, lock_idx_d;

    // While a burst is locked, only its owner may be considered.
    always_comb begin
        w_elig = req_valid;
        if (lock_q) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_elig[i] = req_valid[i] && (lock_idx_q == i[c_PTR_W-1:0]);
            end
        end
    end
`else
    always_comb begin
        w_elig = req_valid;
    end
`endif

    // Search starts just above the last winner and visits the last winner last.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = ptr_q;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_grant = idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_load_en = (state_q == EMPTY) || out_ready;
    assign w_hs      = rst_n && w_load_en && w_found;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (w_grant == i[c_PTR_W-1:0]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (w_hs) begin
            state_d                  = FULL;
            ptr_d                    = w_grant;
            out_data_d               = req_data[w_grant*BIT_WIDTH +: BIT_WIDTH];
            out_src_d                = '0;
            out_src_d[c_PTR_W-1:0]   = w_grant;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef DATA_MUX_ARBITER_LOCK_EN
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (w_hs) begin
            lock_d     = !req_last[w_grant];
            lock_idx_d = w_grant;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= c_PTR_INIT;
            out_data_q <= '0;
            out_src_q  <= '0;
`ifdef DATA_MUX_ARBITER_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
`ifdef DATA_MUX_ARBITER_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: doc/data_mux_arbiter.md
DATA_MUX_ARBITER -- requirements
Module: data_mux_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters, legal range 1..16.
REQ-002 SHALL have parameter BIT_WIDTH, default 32, payload width per requester.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*BIT_WIDTH  packed payloads, requester i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port out_valid  output  1  output register holds a beat.
REQ-009 SHALL have port out_data  output  BIT_WIDTH  registered selected payload.
REQ-010 SHALL have port out_src  output  4  index of requester that supplied out_data.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port req_last  input  NUM_REQ  end-of-burst marker per requester, present only when DATA_MUX_ARBITER_LOCK_EN is defined.

Function
REQ-013 SHALL implement two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL assert load_en = EMPTY or (FULL and out_ready).
REQ-015 SHALL select grant index g round-robin: first i with req_valid[i]=1 searching from ptr+1 upward, wrapping NUM_REQ-1 -> 0, ptr itself searched last.
REQ-016 SHALL drive req_ready[g]=1 combinationally only when load_en=1 and any req_valid set; all other bits 0.
REQ-017 SHALL, on handshake req_valid[g] and req_ready[g], load out_data<=req_data[g], out_src<=g, out_valid<=1, ptr<=g at next edge (latency 1 cycle).
REQ-018 SHALL, in FULL with out_ready=1 and no req_valid, go to EMPTY (out_valid<=0), out_data/out_src hold.
REQ-019 SHALL, in FULL with out_ready=1 and a request present, reload in same cycle (full throughput, one beat per cycle).
REQ-020 SHALL hold out_data, out_src, out_valid stable while out_valid=1 and out_ready=0; req_ready all 0.
REQ-021 SHALL never drop or duplicate a beat; each accepted beat appears exactly once on output.
REQ-022 SHALL, with NUM_REQ=1, degenerate to a one-entry register slice with out_src=0.
REQ-023 SHALL ignore req_data of non-granted requesters entirely (no OR-combination).

Reset
REQ-024 SHALL on rst_n=0 asynchronously set out_valid=0, out_data=0, out_src=0, ptr=NUM_REQ-1 (requester 0 highest first priority), lock cleared, state EMPTY.
REQ-025 SHALL drive req_ready=0 while rst_n=0; a beat in the output register at reset is discarded.
REQ-026 SHALL resume arbitration on the first rising clk after rst_n deasserts.

Configuration
REQ-027 SHALL, when DATA_MUX_ARBITER_LOCK_EN is defined, set lock and lock_idx<=g on a handshake with req_last[g]=0, and clear lock on a handshake from lock_idx with req_last=1.
REQ-028 SHALL, while lock is set, grant only lock_idx (other requesters stall even if valid; nothing granted if lock_idx not valid).
REQ-029 SHALL, when DATA_MUX_ARBITER_LOCK_EN is undefined, omit req_last and lock state; every beat is arbitrated independently.

Verification
REQ-030 Reset: rst_n=0 mid-FULL with out_data=0xDEAD -> out_valid=0, out_data=0, req_ready=0 immediately; first grant after release goes to req 0 when all valid.
REQ-031 Round-robin: NUM_REQ=4, all valid, out_ready=1 continuously -> out_src sequence 0,1,2,3,0 one beat per cycle.
REQ-032 Backpressure: out_ready=0 for 5 cycles with req 2 valid, data 0x1234 -> out_data=0x1234 held, req_ready=0 throughout, single beat delivered when out_ready=1.
REQ-033 Sparse/wrap: ptr=3, only req 1 valid -> grant 1; then only req 3 valid -> grant 3; idle cycle -> out_valid falls to 0.
REQ-034 Lock (macro defined): req 1 sends 3 beats, req_last=1 on third, req 0 and 2 valid throughout -> out_src 1,1,1 then 2, then 0.
REQ-035 Lock (macro undefined): same stimulus -> out_src 1,2,0,1.
